bus8_initiator: RTL and testbench
=================================

Name: bus8_initiator

Overview:
- Bus8 initiator (master). Converts single-word requests from a local command source (e.g. a UART command decoder) into one-cycle Bus8 strobes: CS, Addr8, Wr_Rd_n and Wr_Data.
- Waits for the responder's Rd_DV pulse on reads and returns the read data on a response port.
- A timeout protects against absent or unmapped responders.
- Sits opposite Bus8 responders such as the Bus8 dual-port RAM: one initiator drives one shared Bus8 segment.

Parameters:
- ADDR_WIDTH, 8, width of the Bus8 address (Addr8).
- TIMEOUT, 16, maximum cycles spent waiting for Rd_DV on a read. Must be at least 1.

Ports:
- i_Bus_Clk  in  1  bus clock; all logic on rising edge.
- i_Bus_Rst  in  1  reset, asynchronous, active-high.
- i_Req_Valid  in  1  request present.
- o_Req_Ready  out  1  initiator can accept a request.
- i_Req_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Req_Addr  in  ADDR_WIDTH  target address.
- i_Req_Wr_Data  in  8  write data.
- o_Rsp_DV  out  1  one-cycle response pulse.
- o_Rsp_Data  out  8  read data; valid while o_Rsp_DV = 1.
- o_Rsp_Timeout  out  1  qualifies o_Rsp_DV: read timed out.
- o_Bus_CS  out  1  Bus8 chip select, one-cycle strobe.
- o_Bus_Wr_Rd_n  out  1  Bus8 direction.
- o_Bus_Addr8  out  ADDR_WIDTH  Bus8 address.
- o_Bus_Wr_Data  out  8  Bus8 write data.
- i_Bus_Rd_Data  in  8  Bus8 read data from responder.
- i_Bus_Rd_DV  in  1  Bus8 read-data-valid from responder.

Behaviour:
- Clocking and reset: one clock (i_Bus_Clk); reset i_Bus_Rst is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - o_Req_Ready = 0, then 1 on the first clock after reset release.
  - o_Bus_CS = 0, o_Bus_Wr_Rd_n = 0, o_Bus_Addr8 = 0, o_Bus_Wr_Data = 0.
  - o_Rsp_DV = 0, o_Rsp_Data = 0, o_Rsp_Timeout = 0.
  - FSM = IDLE, timeout counter = 0.
- Reset mid-transaction aborts immediately: CS drops asynchronously and no response is produced.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - o_Req_Ready = 1.
  - On i_Req_Valid & o_Req_Ready, latch Wr_Rd_n, Addr and Wr_Data, then go to ISSUE.
- ISSUE:
  - Exactly one cycle with o_Bus_CS = 1 and the latched Addr, Wr_Rd_n and Wr_Data on the bus.
  - Write: go to IDLE (no response; see optional feature).
  - Read: go to WAIT_RD and clear the counter.
- WAIT_RD:
  - CS = 0. Each cycle, sample i_Bus_Rd_DV.
  - DV = 1: capture i_Bus_Rd_Data into o_Rsp_Data, set Timeout = 0, go to RESP.
  - DV = 0 and counter = TIMEOUT-1: set o_Rsp_Data = 0x00 and Timeout = 1, go to RESP.
  - Otherwise increment the counter.
  - WAIT_RD therefore lasts at most TIMEOUT cycles. DV on the last cycle wins over timeout.
- RESP: o_Rsp_DV = 1 for exactly one cycle, then IDLE.
- o_Rsp_Data and o_Rsp_Timeout hold their values until the next response.
- Latency, counting from the accept edge (cycle A):
  - CS high during cycle A+1.
  - A 1-cycle responder returns DV in A+2; o_Rsp_DV is high in A+3.
  - Write throughput: 1 request per 2 cycles.
- Bus address and write data hold their last values after CS drops; only CS qualifies them.
- i_Bus_Rd_DV in IDLE, ISSUE or RESP is ignored; there is no sticky capture.
- o_Req_Ready is 0 in every state except IDLE. Request inputs are don't-care when Ready = 0.
- Timeout counter width is $clog2(TIMEOUT+1). No wrap, because the FSM exits at TIMEOUT-1.

Optional Feature:
- Macro: BUS8_INITIATOR_WR_ACK_EN.
- Defined: writes go ISSUE -> RESP, giving o_Rsp_DV = 1 in cycle A+2 with o_Rsp_Data = 0x00 and o_Rsp_Timeout = 0. Write throughput becomes 1 request per 3 cycles.
- Undefined: writes produce no response, and ISSUE returns directly to IDLE.

Test Plan:
- Write: request Wr=1, Addr=0x12, Data=0xA5 against a 1-cycle-read Bus8 RAM model -> CS=1 for exactly one cycle with Addr8=0x12, Wr_Data=0xA5, Wr_Rd_n=1; Ready returns to 1 two cycles after accept; no o_Rsp_DV.
- Read-back: write 0x3C to 0x40, then read 0x40 -> CS pulse with Wr_Rd_n=0; o_Rsp_DV in cycle A+3 with Data=0x3C and Timeout=0.
- Timeout: read with no responder (DV tied 0), TIMEOUT=16 -> o_Rsp_DV exactly 17 cycles after CS with Data=0x00 and Timeout=1; next request is accepted.
- Boundary: responder DV on the 16th WAIT_RD cycle with Data=0x77 -> response Data=0x77, Timeout=0. A stray DV in IDLE produces no response.
- Reset mid-read: assert i_Bus_Rst in WAIT_RD -> all outputs zero asynchronously and no o_Rsp_DV. After release, Ready=1 one cycle later and a fresh read of 0x40 returns correct data.
- With BUS8_INITIATOR_WR_ACK_EN: back-to-back writes with Valid held high -> CS pulses every 3 cycles, with o_Rsp_DV and Data=0x00 the cycle after each CS.

Source files
------------

// File: rtl/bus8_initiator.sv
// Bus8 initiator: turns single-word local requests into one-cycle Bus8 strobes and returns read data.
// Optional macro BUS8_INITIATOR_WR_ACK_EN adds a zero-data response pulse after every write.
module bus8_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_Bus_Clk,
    input  logic                  i_Bus_Rst,
    input  logic                  i_Req_Valid,
    output logic                  o_Req_Ready,
    input  logic                  i_Req_Wr_Rd_n,
    input  logic [ADDR_WIDTH-1:0] i_Req_Addr,
    input  logic [7:0]            i_Req_Wr_Data,
    output logic                  o_Rsp_DV,
    output logic [7:0]            o_Rsp_Data,
    output logic                  o_Rsp_Timeout,
    output logic                  o_Bus_CS,
    output logic                  o_Bus_Wr_Rd_n,
    output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
    output logic [7:0]            o_Bus_Wr_Data,
    input  logic [7:0]            i_Bus_Rd_Data,
    input  logic                  i_Bus_Rd_DV
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    cs_q, cs_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    rsp_dv_q, rsp_dv_d;
    logic [7:0]              rsp_data_q, rsp_data_d;
    logic                    rsp_to_q, rsp_to_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = rsp_to_q;

        case (state_q)
            IDLE: begin
                if (i_Req_Valid && ready_q) begin
                    wr_d    = i_Req_Wr_Rd_n;
                    addr_d  = i_Req_Addr;
                    wdata_d = i_Req_Wr_Data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
`ifdef BUS8_INITIATOR_WR_ACK_EN
                    rsp_data_d = 8'h00;
                    rsp_to_d   = 1'b0;
                    state_d    = RESP;
`else
                    state_d    = IDLE;
`endif
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // A DV arriving on the final wait cycle still beats the timeout.
                if (i_Bus_Rd_DV) begin
                    rsp_data_d = i_Bus_Rd_Data;
                    rsp_to_d   = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = 8'h00;
                    rsp_to_d   = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered strobes are derived from the state being entered.
        ready_d  = (state_d == IDLE);
        cs_d     = (state_d == ISSUE);
        rsp_dv_d = (state_d == RESP);
    end

    always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            rsp_dv_q   <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_dv_q   <= rsp_dv_d;
            rsp_data_q <= rsp_data_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    assign o_Req_Ready   = ready_q;
    assign o_Bus_CS      = cs_q;
    assign o_Bus_Wr_Rd_n = wr_q;
    assign o_Bus_Addr8   = addr_q;
    assign o_Bus_Wr_Data = wdata_q;
    assign o_Rsp_DV      = rsp_dv_q;
    assign o_Rsp_Data    = rsp_data_q;
    assign o_Rsp_Timeout = rsp_to_q;

endmodule

// File: tb/tb_bus8_initiator.sv
// Directed bench for bus8_initiator against a 1-cycle Bus8 RAM model with injectable DV.
module tb_bus8_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_dv;
    logic [7:0] rsp_data;
    logic       rsp_to;
    logic       bus_cs;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rdv;

`ifdef BUS8_INITIATOR_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    bus8_initiator #(.ADDR_WIDTH(8), .TIMEOUT(16)) dut (
        .i_Bus_Clk     (clk),
        .i_Bus_Rst     (rst),
        .i_Req_Valid   (req_valid),
        .o_Req_Ready   (req_ready),
        .i_Req_Wr_Rd_n (req_wr),
        .i_Req_Addr    (req_addr),
        .i_Req_Wr_Data (req_data),
        .o_Rsp_DV      (rsp_dv),
        .o_Rsp_Data    (rsp_data),
        .o_Rsp_Timeout (rsp_to),
        .o_Bus_CS      (bus_cs),
        .o_Bus_Wr_Rd_n (bus_wr),
        .o_Bus_Addr8   (bus_addr),
        .o_Bus_Wr_Data (bus_wdata),
        .i_Bus_Rd_Data (bus_rdata),
        .i_Bus_Rd_DV   (bus_rdv)
    );

    always #5 clk = ~clk;

    // Bus8 RAM responder model: one-cycle read latency, not reset by the bus reset.
    logic [7:0] mem [256];
    logic       ram_dv = 1'b0;
    logic [7:0] ram_q = 8'h00;
    logic       respond_en = 1'b1;
    logic       force_dv = 1'b0;
    logic [7:0] force_data = 8'h00;

    always @(posedge clk) begin
        ram_dv <= respond_en & bus_cs & ~bus_wr;
        if (bus_cs && !bus_wr) ram_q <= mem[bus_addr];
        if (bus_cs && bus_wr) mem[bus_addr] <= bus_wdata;
    end

    assign bus_rdv   = ram_dv | force_dv;
    assign bus_rdata = force_dv ? force_data : ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cs_cnt = 0, cs_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    logic [7:0] cs_addr = 8'h00, cs_wdata = 8'h00, rsp_d = 8'h00;
    logic cs_wr = 1'b0, rsp_t = 1'b0;

    always @(negedge clk) begin
        if (bus_cs) begin
            cs_cnt++; cs_cyc = cyc; cs_addr = bus_addr; cs_wr = bus_wr; cs_wdata = bus_wdata;
        end
        if (rsp_dv) begin
            rsp_cnt++; rsp_cyc = cyc; rsp_d = rsp_data; rsp_t = rsp_to;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for its accept edge; acc is the cycle index in which CS should be high.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data, output int acc);
        int n = 0;
        while (!req_ready && n < 50) begin tick(1); n++; end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
        tick(1);
        acc = cyc;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int acc, cs0, rsp0, exp_rsp, exp_lat;
        logic [7:0] exp_d;
        logic [7:0] cs_pat, dv_pat;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 8'h40, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 8'h40, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 8'h12, 8'h00, 8'hA5};
        vecs[4] = '{1'b1, 8'h12, 8'h5A, 8'h00};
        vecs[5] = '{1'b0, 8'h12, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[7] = '{1'b1, 8'hFF, 8'h81, 8'h00};
        vecs[8] = '{1'b0, 8'hFF, 8'h00, 8'h81};

        // Reset state
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_bus", {bus_cs, bus_wr, 6'd0, bus_addr, bus_wdata, 8'd0}, 32'd0);
        chk("rst_rsp", {rsp_dv, rsp_to, 14'd0, rsp_data, 8'd0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready_lo", {31'd0, req_ready}, 32'd0);
        tick(1);
        chk("rel_ready_hi", {31'd0, req_ready}, 32'd1);

        // Single write: CS pulse contents and Ready recovery
        cs0 = cs_cnt; rsp0 = rsp_cnt;
        issue(1'b1, 8'h12, 8'hA5, acc);
        chk("wr_cs_now", {31'd0, bus_cs}, 32'd1);
        chk("wr_ready_lo", {31'd0, req_ready}, 32'd0);
        tick(1);
        chk("wr_ready_back", {31'd0, req_ready}, WR_ACK ? 32'd0 : 32'd1);
        tick(6);
        chk("wr_cs_cnt", cs_cnt - cs0, 32'd1);
        chk("wr_cs_fields", {cs_wr, cs_addr, cs_wdata}, {1'b1, 8'h12, 8'hA5});
        chk("wr_rsp_cnt", rsp_cnt - rsp0, WR_ACK ? 32'd1 : 32'd0);

        // Table-driven writes and reads
        for (int i = 0; i < 9; i++) begin
            cs0 = cs_cnt; rsp0 = rsp_cnt;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].data, acc);
            tick(8);
            exp_rsp = vecs[i].wr ? int'(WR_ACK) : 1;
            exp_lat = vecs[i].wr ? 1 : 2;
            exp_d   = vecs[i].wr ? 8'h00 : vecs[i].exp_data;
            chk($sformatf("v%0d_cs_cnt", i), cs_cnt - cs0, 32'd1);
            chk($sformatf("v%0d_cs_cyc", i), cs_cyc, acc);
            chk($sformatf("v%0d_cs_fields", i), {cs_wr, cs_addr, cs_wdata},
                {vecs[i].wr, vecs[i].addr, vecs[i].wr ? vecs[i].data : cs_wdata});
            chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt - rsp0, exp_rsp);
            if (exp_rsp == 1) begin
                chk($sformatf("v%0d_rsp_cyc", i), rsp_cyc, acc + exp_lat);
                chk($sformatf("v%0d_rsp_data", i), {rsp_t, rsp_d}, {1'b0, exp_d});
            end
        end

        // Timeout with no responder
        respond_en = 1'b0;
        cs0 = cs_cnt; rsp0 = rsp_cnt;
        issue(1'b0, 8'h40, 8'h00, acc);
        tick(25);
        chk("to_rsp_cnt", rsp_cnt - rsp0, 32'd1);
        chk("to_latency", rsp_cyc - cs_cyc, 32'd17);
        chk("to_data", {rsp_t, rsp_d}, {1'b1, 8'h00});
        chk("to_hold", {rsp_to, rsp_data}, {1'b1, 8'h00});

        // Boundary: DV on the 16th wait cycle still wins
        rsp0 = rsp_cnt;
        issue(1'b0, 8'h40, 8'h00, acc);
        tick(16);
        force_data = 8'h77; force_dv = 1'b1;
        tick(1);
        force_dv = 1'b0;
        tick(4);
        chk("bnd_rsp_cnt", rsp_cnt - rsp0, 32'd1);
        chk("bnd_rsp_cyc", rsp_cyc, acc + 17);
        chk("bnd_data", {rsp_t, rsp_d}, {1'b0, 8'h77});

        // Stray DV while idle
        rsp0 = rsp_cnt;
        force_data = 8'hEE; force_dv = 1'b1;
        tick(1);
        force_dv = 1'b0;
        tick(4);
        chk("stray_rsp_cnt", rsp_cnt - rsp0, 32'd0);
        chk("stray_hold", {rsp_to, rsp_data}, {1'b0, 8'h77});

        // Reset in the middle of a read wait
        rsp0 = rsp_cnt;
        issue(1'b0, 8'h40, 8'h00, acc);
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bus", {bus_cs, bus_wr, 6'd0, bus_addr, bus_wdata, 8'd0}, 32'd0);
        chk("mid_rst_rsp", {req_ready, rsp_dv, rsp_to, 13'd0, rsp_data, 8'd0}, 32'd0);
        respond_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready_lo", {31'd0, req_ready}, 32'd0);
        tick(1);
        chk("mid_rel_ready_hi", {31'd0, req_ready}, 32'd1);
        tick(20);
        chk("mid_no_rsp", rsp_cnt - rsp0, 32'd0);
        issue(1'b0, 8'h40, 8'h00, acc);
        tick(6);
        chk("mid_reread_cnt", rsp_cnt - rsp0, 32'd1);
        chk("mid_reread_data", {rsp_t, rsp_d}, {1'b0, 8'h3C});

`ifdef BUS8_INITIATOR_WR_ACK_EN
        // Back-to-back writes with Valid held high
        req_wr = 1'b1; req_addr = 8'h20; req_data = 8'h99; req_valid = 1'b1;
        cs_pat = 8'h00; dv_pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            cs_pat[i] = bus_cs;
            dv_pat[i] = rsp_dv & (rsp_data == 8'h00) & ~rsp_to;
        end
        req_valid = 1'b0;
        chk("b2b_cs_pattern", {24'd0, cs_pat}, 32'h49);
        chk("b2b_dv_pattern", {24'd0, dv_pat}, 32'h92);
        tick(4);
`else
        cs_pat = 8'h00; dv_pat = 8'h00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
